// File: rtl/instr_decode_if.sv
// Fetch-to-decode handshake bundle: upstream instruction offer, flush,
// and the decoded instruction presented to the immediate generator.
interface instr_decode_if #(
    parameter int unsigned PC_W = 32
);
    logic            if_valid_in;
    logic [31:0]     if_instr_in;
    logic [PC_W-1:0] if_pc_in;
    logic            if_ready_o;
    logic            flush_in;
    logic            id_valid_o;
    logic            id_ready_in;
    logic [31:0]     id_instr_o;
    logic [PC_W-1:0] id_pc_o;
    logic [2:0]      imm_type_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic [4:0]      rd_o;
    logic            illegal_o;

    // Pipeline control side: drives the instruction offer, flush and consume.
    modport master (
        output if_valid_in, if_instr_in, if_pc_in, flush_in, id_ready_in,
        input  if_ready_o, id_valid_o, id_instr_o, id_pc_o, imm_type_o,
               rs1_o, rs2_o, rd_o, illegal_o
    );

    // Decode stage side.
    modport slave (
        input  if_valid_in, if_instr_in, if_pc_in, flush_in, id_ready_in,
        output if_ready_o, id_valid_o, id_instr_o, id_pc_o, imm_type_o,
               rs1_o, rs2_o, rd_o, illegal_o
    );
endinterface

// File: rtl/instr_decode_stage.sv
// Instruction decode stage: two-entry skid buffer (OUT + SKID) that decodes the
// immediate format and legality at capture so every output comes from a register.
module instr_decode_stage #(
    parameter int unsigned PC_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    instr_decode_if.slave  bus
);
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned IMM_W   = 3;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [IMM_W-1:0]   imm_type;
        logic               illegal;
    } entry_t;

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    entry_t new_entry;
    logic   ready_q;
    logic   in_fire;
    logic   out_fire;

    // Opcode -> {illegal, imm_type}; unknown opcodes report format 000.
    function automatic logic [IMM_W:0] decode_opcode(input logic [6:0] opc);
        logic [IMM_W:0] res;
        res = {1'b1, 3'b000};
        case (opc)
            7'b0110011: res = {1'b0, 3'b000};
            7'b0010011,
            7'b0000011,
            7'b1100111,
            7'b1110011,
            7'b0001111: res = {1'b0, 3'b001};
            7'b1100011: res = {1'b0, 3'b011};
            7'b0110111,
            7'b0010111: res = {1'b0, 3'b100};
            7'b1101111: res = {1'b0, 3'b101};
            7'b0100011: res = {1'b0, 3'b110};
            default:    res = {1'b1, 3'b000};
        endcase
        return res;
    endfunction

    assign in_fire  = bus.if_valid_in & ready_q & ~bus.flush_in;
    assign out_fire = out_q.valid & bus.id_ready_in;

    always_comb begin
        logic [IMM_W:0] dec;
        dec                = decode_opcode(bus.if_instr_in[6:0]);
        new_entry.valid    = 1'b1;
        new_entry.instr    = bus.if_instr_in;
        new_entry.pc       = bus.if_pc_in;
        new_entry.imm_type = dec[IMM_W-1:0];
        new_entry.illegal  = dec[IMM_W];
    end

    // Next-state for both entries; flush only clears the valid bits.
    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        if (bus.flush_in) begin
            out_d.valid  = 1'b0;
            skid_d.valid = 1'b0;
        end else if (!out_q.valid || out_fire) begin
            if (skid_q.valid) begin
                out_d = skid_q;
                if (in_fire) begin
                    skid_d = new_entry;
                end else begin
                    skid_d.valid = 1'b0;
                end
            end else if (in_fire) begin
                out_d = new_entry;
            end else begin
                out_d.valid = 1'b0;
            end
        end else if (in_fire) begin
            skid_d = new_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ~skid_d.valid;
        end
    end

    assign bus.if_ready_o = ready_q;
    assign bus.id_valid_o = out_q.valid;
    assign bus.id_instr_o = out_q.instr;
    assign bus.id_pc_o    = out_q.pc;
    assign bus.imm_type_o = out_q.imm_type;
    assign bus.illegal_o  = out_q.illegal;
    assign bus.rs1_o      = out_q.instr[19:15];
    assign bus.rs2_o      = out_q.instr[24:20];
    assign bus.rd_o       = out_q.instr[11:7];

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed and randomized checks of instr_decode_stage: decode table, skid
// backpressure, flush, reset and ordered delivery under random stalls.
module tb_instr_decode_stage;
    localparam int unsigned PC_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    instr_decode_if #(.PC_W(PC_W)) bus ();

    instr_decode_stage #(.PC_W(PC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent reference for the immediate-format table: {illegal, imm_type}.
    function automatic logic [3:0] ref_decode(input logic [31:0] instr);
        case (instr[6:0])
            7'h33:                          return 4'b0_000;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: return 4'b0_001;
            7'h63:                          return 4'b0_011;
            7'h37, 7'h17:                   return 4'b0_100;
            7'h6F:                          return 4'b0_101;
            7'h23:                          return 4'b0_110;
            default:                        return 4'b1_000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        bus.if_valid_in = v;
        bus.if_instr_in = instr;
        bus.if_pc_in    = pc;
    endtask

    logic [31:0] tbl_instr [0:4];
    logic [2:0]  tbl_imm   [0:4];
    logic [6:0]  opcs      [0:11];

    initial begin
        bus.if_valid_in = 1'b0;
        bus.if_instr_in = '0;
        bus.if_pc_in    = '0;
        bus.flush_in    = 1'b0;
        bus.id_ready_in = 1'b0;
        tick();
        tick();
        check("reset_valid", 64'(bus.id_valid_o), 64'd0);
        check("reset_ready", 64'(bus.if_ready_o), 64'd1);
        rst = 1'b0;

        // Stream: ADDI x1, x0, 5
        bus.id_ready_in = 1'b1;
        offer(1'b1, 32'h0050_0093, 32'h100);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        check("stream_valid", 64'(bus.id_valid_o), 64'd1);
        check("stream_imm",   64'(bus.imm_type_o), 64'd1);
        check("stream_rd",    64'(bus.rd_o),       64'd1);
        check("stream_rs1",   64'(bus.rs1_o),      64'd0);
        check("stream_ill",   64'(bus.illegal_o),  64'd0);
        check("stream_pc",    64'(bus.id_pc_o),    64'h100);
        tick();
        check("stream_drained", 64'(bus.id_valid_o), 64'd0);

        // Backpressure: store into OUT, branch into SKID.
        bus.id_ready_in = 1'b0;
        offer(1'b1, 32'h00A1_2023, 32'h200);
        tick();
        check("bp_ready_after1", 64'(bus.if_ready_o), 64'd1);
        offer(1'b1, 32'hFE00_0EE3, 32'h204);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        check("bp_ready_full", 64'(bus.if_ready_o), 64'd0);
        check("bp_out_imm",    64'(bus.imm_type_o), 64'd6);
        check("bp_out_rs1",    64'(bus.rs1_o),      64'd2);
        check("bp_out_rs2",    64'(bus.rs2_o),      64'd10);
        tick();
        check("bp_hold_instr", 64'(bus.id_instr_o), 64'h00A1_2023);
        check("bp_hold_pc",    64'(bus.id_pc_o),    64'h200);
        bus.id_ready_in = 1'b1;
        tick();
        check("bp_second_valid", 64'(bus.id_valid_o), 64'd1);
        check("bp_second_imm",   64'(bus.imm_type_o), 64'd3);
        check("bp_second_instr", 64'(bus.id_instr_o), 64'hFE00_0EE3);
        check("bp_ready_again",  64'(bus.if_ready_o), 64'd1);
        tick();
        check("bp_drained", 64'(bus.id_valid_o), 64'd0);

        // Flush with both entries full and a word offered.
        bus.id_ready_in = 1'b0;
        offer(1'b1, 32'h0000_0033, 32'h300);
        tick();
        offer(1'b1, 32'h0000_0037, 32'h304);
        tick();
        check("fl_full", 64'(bus.if_ready_o), 64'd0);
        offer(1'b1, 32'h1111_1113, 32'h308);
        bus.flush_in = 1'b1;
        tick();
        bus.flush_in = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check("fl_valid", 64'(bus.id_valid_o), 64'd0);
        check("fl_ready", 64'(bus.if_ready_o), 64'd1);
        bus.id_ready_in = 1'b1;
        tick();
        check("fl_no_ghost", 64'(bus.id_valid_o), 64'd0);

        // Illegal opcode then a legal one back to back.
        offer(1'b1, 32'h0000_007F, 32'h400);
        tick();
        check("ill_valid", 64'(bus.id_valid_o), 64'd1);
        check("ill_flag",  64'(bus.illegal_o),  64'd1);
        check("ill_imm",   64'(bus.imm_type_o), 64'd0);
        offer(1'b1, 32'h0000_0013, 32'h404);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        check("legal_flag", 64'(bus.illegal_o),  64'd0);
        check("legal_pc",   64'(bus.id_pc_o),    64'h404);
        tick();

        // Remaining formats.
        tbl_instr = '{32'h0000_0033, 32'h0000_0037, 32'h0000_0017, 32'h0000_006F, 32'h0000_0067};
        tbl_imm   = '{3'd0, 3'd4, 3'd4, 3'd5, 3'd1};
        for (int i = 0; i < 5; i++) begin
            offer(1'b1, tbl_instr[i], 32'h500 + 32'(i * 4));
            tick();
            check("fmt_imm", 64'(bus.imm_type_o), 64'(tbl_imm[i]));
            check("fmt_ill", 64'(bus.illegal_o),  64'd0);
        end
        offer(1'b0, 32'h0, 32'h0);
        tick();

        // Reset mid-stream with both entries full.
        bus.id_ready_in = 1'b0;
        offer(1'b1, 32'hFFFF_FFEF, 32'h600);
        tick();
        offer(1'b1, 32'hFFFF_FFE3, 32'h604);
        tick();
        rst = 1'b1;
        offer(1'b1, 32'hFFFF_FFB3, 32'h608);
        tick();
        rst = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check("rst_valid", 64'(bus.id_valid_o), 64'd0);
        check("rst_ready", 64'(bus.if_ready_o), 64'd1);
        check("rst_instr", 64'(bus.id_instr_o), 64'd0);
        check("rst_pc",    64'(bus.id_pc_o),    64'd0);
        check("rst_imm",   64'(bus.imm_type_o), 64'd0);
        check("rst_regs",  64'({bus.rs1_o, bus.rs2_o, bus.rd_o}), 64'd0);
        check("rst_ill",   64'(bus.illegal_o),  64'd0);
        offer(1'b1, 32'h0000_0013, 32'h700);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        check("rst_after_valid", 64'(bus.id_valid_o), 64'd1);
        check("rst_after_pc",    64'(bus.id_pc_o),    64'h700);
        bus.id_ready_in = 1'b1;
        tick();

        // Random valid/ready stress with an ordered scoreboard.
        opcs = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h23, 7'h7F};
        begin
            logic [63:0] exp_q [$];
            int          sent = 0;
            int          got = 0;
            int          cycles = 0;
            logic [31:0] instr;
            logic        in_fire, out_fire, stalled;
            logic [63:0] hold_snap;
            logic [3:0]  hold_dec;
            logic [63:0] e;
            logic [3:0]  d;
            while (got < 10000 && cycles < 60000) begin
                instr = {$urandom(), 7'h0};
                instr[6:0] = opcs[$urandom_range(11)];
                offer((sent < 10000) && ($urandom_range(9) < 7), instr, 32'(sent * 4));
                bus.id_ready_in = ($urandom_range(9) < 6);
                #1;
                in_fire  = bus.if_valid_in & bus.if_ready_o;
                out_fire = bus.id_valid_o & bus.id_ready_in;
                stalled  = bus.id_valid_o & ~bus.id_ready_in;
                hold_snap = {bus.id_instr_o, bus.id_pc_o};
                hold_dec  = {bus.illegal_o, bus.imm_type_o};
                if (out_fire) begin
                    if (exp_q.size() == 0) begin
                        check("st_underflow", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        d = ref_decode(e[63:32]);
                        check("st_order", {bus.id_instr_o, bus.id_pc_o}, e);
                        check("st_decode", 64'({bus.illegal_o, bus.imm_type_o}), 64'(d));
                    end
                    got++;
                end
                if (in_fire) begin
                    exp_q.push_back({bus.if_instr_in, bus.if_pc_in});
                    sent++;
                end
                tick();
                cycles++;
                if (stalled) begin
                    check("st_hold_valid", 64'(bus.id_valid_o), 64'd1);
                    check("st_hold_data",  {bus.id_instr_o, bus.id_pc_o}, hold_snap);
                    check("st_hold_dec",   64'({bus.illegal_o, bus.imm_type_o}), 64'(hold_dec));
                end
            end
            check("st_complete", 64'(got), 64'd10000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
